sparserdes_stream: RTL and testbench
====================================

Name: sparserdes_stream

Overview:
- Next-generation sparse bit-array serializer/deserializer for any power-of-two SIZE.
- Replaces the settle-then-iterate combinational tree with a single depth-first traversal engine.
- The engine walks a binary occupancy tree and emits/consumes child-occupancy flags over valid/ready bit streams.
- Sits between a host command port and a narrow link, e.g. a spike-address bus between cores.

Parameters:
SIZE, 8, number of leaf bits; power of two, >= 2
AW, $clog2(SIZE), leaf address width (derived, not overridden)
DEPTH, $clog2(SIZE), tree levels above leaves (derived)
CW, $clog2(2*SIZE), bit_count width (derived)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  high only in IDLE
cmd_op  in  3  0 NOP, 1 READ, 2 CLEAR_ALL, 3 ENCODE, 4 ROTATE, 5 SET, 6 CLR, 7 DECODE
cmd_addr  in  AW  leaf address or rotate amount
rd_data  out  1  leaf value latched by READ
tx_valid  out  1  tx_bit valid
tx_bit  out  1  serialized flag
tx_ready  in  1  sink accepts tx_bit
rx_valid  in  1  rx_bit valid
rx_bit  in  1  incoming flag
rx_ready  out  1  engine accepts rx_bit
done  out  1  one-cycle pulse at end of ENCODE/DECODE
error  out  1  malformed DECODE stream; sticky until next accepted command
bit_count  out  CW  flags transferred by last ENCODE/DECODE
leaf_vec  out  SIZE  current leaf register

Behaviour:
- Reset (async assert): state IDLE; leaf_vec=0; rd_data=0; tx_valid=0; rx_ready=0; done=0; error=0; bit_count=0; cmd_ready=1 after release. Reset mid-operation abandons the transfer; no done pulse.
- A command is accepted on cmd_valid & cmd_ready. Accepting any command clears error.
- Single-cycle ops (result visible the next cycle; stay in IDLE):
  - READ: rd_data <= leaf[cmd_addr].
  - CLEAR_ALL: all leaves <= 0.
  - SET / CLR: leaf[cmd_addr] <= 1 / 0.
  - ROTATE: circular left shift of the leaves by cmd_addr, mod SIZE; amount 0 leaves them unchanged.
- Tree: node (l,i), l=1..DEPTH, covers leaves [i*2^l, (i+1)*2^l). It is nonempty iff any covered leaf is 1, computed combinationally from leaf_vec. The root is (DEPTH,0).
- Stream format:
  - Pre-order depth-first traversal starting at the root.
  - Each visited node emits two flags: low-child nonempty, then high-child nonempty.
  - A child at l >= 1 with flag 1 is visited low-first.
  - Level-0 children are leaves and emit nothing further.
  - The root is always visited; an empty array yields "0,0".
  - Total flags = 2 x visited nodes; maximum 2*(SIZE-1).
- Traversal state: current (level, index), phase (LO/HI), and per-level pending-high register pend[DEPTH:1].
  - After a node's HI flag, descend to the low child if its flag is 1 and level > 1.
  - Otherwise descend to the high child if its flag is 1 and level > 1.
  - Otherwise backtrack to the lowest level with pend set, clear that pend, and visit that node's high sibling.
  - No pend set means the traversal is finished.
- FSM: IDLE -> ENC (ENCODE) or DEC (DECODE) -> FIN -> IDLE.
  - FIN lasts one cycle and asserts done.
  - cmd_ready=0 outside IDLE.
  - bit_count is cleared on entering ENC/DEC and increments per handshake.
- ENC:
  - tx_valid rises the cycle after acceptance; one flag transfers per tx_valid & tx_ready cycle.
  - tx_bit is stable while stalled.
  - Zero-bubble: back-to-back flags when tx_ready stays 1.
  - tx_valid drops the cycle after the last handshake.
  - Leaf modification during ENC is impossible (cmd_ready=0).
- DEC:
  - rx_ready=1 while in DEC; a flag is consumed per rx_valid & rx_ready cycle.
  - A flag of 1 for a level-0 child ORs that leaf to 1 (union with existing contents).
  - Traversal follows received flags, not leaf_vec.
  - Error: a non-root node receiving "0,0". On error: error=1, go to FIN (done still pulses), remaining stream not consumed, leaves already set are kept.
- done pulses exactly once per ENCODE/DECODE. It is concurrent with error in the error case.

Test Plan:
- SIZE=8, SET 2, ENCODE, tx_ready=1 -> tx_bit sequence 1,0,0,1,1,0; bit_count=6; one done pulse; cmd_ready high after FIN.
- CLEAR_ALL, ENCODE -> 0,0; bit_count=2. SET all 8, ENCODE -> 14 ones; bit_count=14.
- CLEAR_ALL, DECODE stream 1,0,0,1,1,0 -> leaf_vec=8'h04, error=0. Repeat with leaf_vec preset 8'h80 -> 8'h84.
- DECODE 1,0,0,0 -> error=1 with done after the 4th flag; leaf_vec unchanged. Next READ clears error.
- ENCODE of leaf_vec=8'hA5 with random tx_ready stalls -> identical flag sequence to the no-stall run; tx_bit stable during stalls. ROTATE by 3 of 8'h81 -> 8'h0C.
- Assert reset mid-ENCODE after 3 flags -> all outputs at reset values immediately; no done pulse; after release, a fresh ENCODE is accepted.

Source files
------------

// File: rtl/sparserdes_stream.sv
// Sparse bit-array serializer/deserializer: a depth-first walk over a binary occupancy tree
// emits (ENCODE) or consumes (DECODE) child-occupancy flags on valid/ready bit streams.
module sparserdes_stream #(
  parameter int unsigned SIZE = 8,
  localparam int unsigned AW = $clog2(SIZE),
  localparam int unsigned DEPTH = $clog2(SIZE),
  localparam int unsigned CW = $clog2(2 * SIZE)
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_cmd_valid,
  output logic            o_cmd_ready,
  input  logic [2:0]      i_cmd_op,
  input  logic [AW-1:0]   i_cmd_addr,
  output logic            o_rd_data,
  output logic            o_tx_valid,
  output logic            o_tx_bit,
  input  logic            i_tx_ready,
  input  logic            i_rx_valid,
  input  logic            i_rx_bit,
  output logic            o_rx_ready,
  output logic            o_done,
  output logic            o_error,
  output logic [CW-1:0]   o_bit_count,
  output logic [SIZE-1:0] o_leaf_vec
);

  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam logic [LW-1:0] RootLvl = LW'(DEPTH);
  localparam logic [LW-1:0] LeafParentLvl = LW'(1);

  localparam logic [2:0] OpRead   = 3'd1;
  localparam logic [2:0] OpClrAll = 3'd2;
  localparam logic [2:0] OpEncode = 3'd3;
  localparam logic [2:0] OpRotate = 3'd4;
  localparam logic [2:0] OpSet    = 3'd5;
  localparam logic [2:0] OpClr    = 3'd6;
  localparam logic [2:0] OpDecode = 3'd7;

  typedef enum logic [1:0] {StIdle, StEnc, StDec, StFin} state_e;

  state_e          r_state;
  logic [SIZE-1:0] r_leaf;
  logic            r_rd;
  logic            r_tx_valid;
  logic            r_rx_ready;
  logic            r_done;
  logic            r_error;
  logic [CW-1:0]   r_cnt;
  logic [LW-1:0]   r_lvl;
  logic [AW-1:0]   r_idx;
  logic            r_hi;
  logic            r_lo;
  logic [DEPTH:1]  r_pend;

  logic            w_accept;
  logic            w_occ_lo;
  logic            w_occ_hi;
  logic            w_fl;
  logic            w_fh;
  logic            w_xfer;
  logic            w_bad;
  logic            w_finish;
  logic [LW-1:0]   w_nxt_lvl;
  logic [AW-1:0]   w_nxt_idx;
  logic [DEPTH:1]  w_nxt_pend;
  logic [SIZE-1:0] w_rot;
  logic [AW-1:0]   w_lo_leaf;
  logic [AW-1:0]   w_hi_leaf;

  // Nonempty test for node (lvl, idx): OR of the 2^lvl leaves it covers.
  function automatic logic occ(input logic [SIZE-1:0] v, input int lvl, input int idx);
    int span;
    logic [SIZE-1:0] mask;
    span = 1 << lvl;
    mask = {SIZE{1'b1}} >> (SIZE - span);
    return |(v & (mask << (idx * span)));
  endfunction

  assign w_accept    = i_cmd_valid && (r_state == StIdle);
  assign w_occ_lo    = occ(r_leaf, int'(r_lvl) - 1, 2 * int'(r_idx));
  assign w_occ_hi    = occ(r_leaf, int'(r_lvl) - 1, 2 * int'(r_idx) + 1);
  assign w_fl        = (r_state == StEnc) ? w_occ_lo : r_lo;
  assign w_fh        = (r_state == StEnc) ? w_occ_hi : i_rx_bit;
  assign w_xfer      = ((r_state == StEnc) && r_tx_valid && i_tx_ready) ||
                       ((r_state == StDec) && r_rx_ready && i_rx_valid);
  // Only the HI flag can complete a malformed "0,0" pair at a non-root node.
  assign w_bad       = (r_state == StDec) && r_hi && (r_lvl != RootLvl) && !r_lo && !i_rx_bit;
  assign w_lo_leaf   = r_idx << 1;
  assign w_hi_leaf   = (r_idx << 1) | AW'(1);

  always_comb begin
    w_rot = '0;
    for (int j = 0; j < SIZE; j++) begin
      w_rot[j] = r_leaf[AW'(j) - i_cmd_addr];
    end
  end

  always_comb begin
    int bk;
    logic found;
    w_nxt_lvl  = r_lvl;
    w_nxt_idx  = r_idx;
    w_nxt_pend = r_pend;
    w_finish   = 1'b0;
    bk         = 0;
    found      = 1'b0;
    if (w_fl && (r_lvl > LeafParentLvl)) begin
      w_nxt_lvl = r_lvl - LW'(1);
      w_nxt_idx = r_idx << 1;
      if (w_fh) w_nxt_pend[r_lvl - LW'(1)] = 1'b1;
    end else if (w_fh && (r_lvl > LeafParentLvl)) begin
      w_nxt_lvl = r_lvl - LW'(1);
      w_nxt_idx = (r_idx << 1) | AW'(1);
    end else begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (r_pend[k]) begin
          bk    = k;
          found = 1'b1;
        end
      end
      w_finish = !found;
      if (found) begin
        w_nxt_lvl      = LW'(bk);
        w_nxt_idx      = (r_idx >> (bk - int'(r_lvl))) | AW'(1);
        w_nxt_pend[bk] = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= StIdle;
      r_leaf     <= '0;
      r_rd       <= 1'b0;
      r_tx_valid <= 1'b0;
      r_rx_ready <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_cnt      <= '0;
      r_lvl      <= RootLvl;
      r_idx      <= '0;
      r_hi       <= 1'b0;
      r_lo       <= 1'b0;
      r_pend     <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_error <= 1'b0;
            r_lvl   <= RootLvl;
            r_idx   <= '0;
            r_hi    <= 1'b0;
            r_pend  <= '0;
            case (i_cmd_op)
              OpRead:   r_rd <= r_leaf[i_cmd_addr];
              OpClrAll: r_leaf <= '0;
              OpSet:    r_leaf[i_cmd_addr] <= 1'b1;
              OpClr:    r_leaf[i_cmd_addr] <= 1'b0;
              OpRotate: r_leaf <= w_rot;
              OpEncode: begin
                r_state    <= StEnc;
                r_tx_valid <= 1'b1;
                r_cnt      <= '0;
              end
              OpDecode: begin
                r_state    <= StDec;
                r_rx_ready <= 1'b1;
                r_cnt      <= '0;
              end
              default: ;
            endcase
          end
        end
        StEnc, StDec: begin
          if (w_xfer) begin
            r_cnt <= r_cnt + CW'(1);
            if (!r_hi) begin
              r_hi <= 1'b1;
              r_lo <= i_rx_bit;
            end else if (w_bad) begin
              r_error    <= 1'b1;
              r_done     <= 1'b1;
              r_rx_ready <= 1'b0;
              r_state    <= StFin;
            end else begin
              if ((r_state == StDec) && (r_lvl == LeafParentLvl)) begin
                r_leaf[w_lo_leaf] <= r_leaf[w_lo_leaf] | r_lo;
                r_leaf[w_hi_leaf] <= r_leaf[w_hi_leaf] | i_rx_bit;
              end
              r_hi <= 1'b0;
              if (w_finish) begin
                r_state    <= StFin;
                r_done     <= 1'b1;
                r_tx_valid <= 1'b0;
                r_rx_ready <= 1'b0;
              end else begin
                r_lvl  <= w_nxt_lvl;
                r_idx  <= w_nxt_idx;
                r_pend <= w_nxt_pend;
              end
            end
          end
        end
        StFin: r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_cmd_ready = (r_state == StIdle);
  assign o_rd_data   = r_rd;
  assign o_tx_valid  = r_tx_valid;
  assign o_tx_bit    = r_hi ? w_occ_hi : w_occ_lo;
  assign o_rx_ready  = r_rx_ready;
  assign o_done      = r_done;
  assign o_error     = r_error;
  assign o_bit_count = r_cnt;
  assign o_leaf_vec  = r_leaf;

endmodule

// File: tb/tb_sparserdes_stream.sv
// Self-checking bench for sparserdes_stream (SIZE=8): command table, hand-written stream
// sequences and randomized traffic against a stack-based traversal model.
module tb_sparserdes_stream;

  localparam int SIZE = 8;
  localparam int DEPTH = 3;
  localparam logic [2:0] OP_NOP = 3'd0, OP_READ = 3'd1, OP_CLRALL = 3'd2, OP_ENCODE = 3'd3;
  localparam logic [2:0] OP_ROTATE = 3'd4, OP_SET = 3'd5, OP_CLR = 3'd6, OP_DECODE = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid, cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_addr;
  logic       rd_data, tx_valid, tx_bit, tx_ready;
  logic       rx_valid, rx_bit, rx_ready, done, error;
  logic [3:0] bit_count;
  logic [7:0] leaf_vec;

  always #5 clk = ~clk;

  sparserdes_stream #(.SIZE(SIZE)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_op(cmd_op), .i_cmd_addr(cmd_addr), .o_rd_data(rd_data), .o_tx_valid(tx_valid),
    .o_tx_bit(tx_bit), .i_tx_ready(tx_ready), .i_rx_valid(rx_valid), .i_rx_bit(rx_bit),
    .o_rx_ready(rx_ready), .o_done(done), .o_error(error), .o_bit_count(bit_count),
    .o_leaf_vec(leaf_vec)
  );

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  bit got_q[$];
  bit stim_q[$];
  logic [7:0] exp_leaf;
  bit exp_err;
  int exp_cons;

  typedef struct {
    logic [2:0] op;
    int         addr;
    logic [7:0] exp_leaf;
    logic       exp_rd;
  } vec_t;
  vec_t tbl[14];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  function automatic bit occ(input logic [7:0] v, input int l, input int i);
    int span = 1 << l;
    return ((int'(v) >> (i * span)) & ((1 << span) - 1)) != 0;
  endfunction

  // Pre-order walk with an explicit stack: push high child first so the low child pops first.
  task automatic model_encode(input logic [7:0] v);
    int sl[$], si[$];
    int l, i;
    bit fl, fh;
    exp_q.delete();
    sl.push_back(DEPTH); si.push_back(0);
    while (sl.size() > 0) begin
      l = sl.pop_back(); i = si.pop_back();
      fl = occ(v, l - 1, 2 * i); fh = occ(v, l - 1, 2 * i + 1);
      exp_q.push_back(fl); exp_q.push_back(fh);
      if (l > 1 && fh) begin sl.push_back(l - 1); si.push_back(2 * i + 1); end
      if (l > 1 && fl) begin sl.push_back(l - 1); si.push_back(2 * i); end
    end
  endtask

  task automatic model_decode(input logic [7:0] preset);
    int sl[$], si[$];
    int l, i, p;
    bit fl, fh;
    exp_leaf = preset; exp_err = 0; p = 0;
    sl.push_back(DEPTH); si.push_back(0);
    while (sl.size() > 0) begin
      l = sl.pop_back(); i = si.pop_back();
      if (p + 1 >= stim_q.size()) break;
      fl = stim_q[p]; fh = stim_q[p + 1]; p += 2;
      if (l != DEPTH && !fl && !fh) begin exp_err = 1; break; end
      if (l == 1) begin
        if (fl) exp_leaf[2 * i] = 1'b1;
        if (fh) exp_leaf[2 * i + 1] = 1'b1;
      end else begin
        if (fh) begin sl.push_back(l - 1); si.push_back(2 * i + 1); end
        if (fl) begin sl.push_back(l - 1); si.push_back(2 * i); end
      end
    end
    exp_cons = p;
  endtask

  function automatic int pack_got();
    int r = 0;
    foreach (got_q[k]) r = (r << 1) | int'(got_q[k]);
    return r;
  endfunction

  task automatic cmd(input logic [2:0] op, input int addr);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 50) begin @(negedge clk); n++; end
    chk("cmd_ready_wait", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = 3'(addr);
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = OP_NOP;
  endtask

  task automatic set_leaves(input logic [7:0] v);
    cmd(OP_CLRALL, 0);
    for (int i = 0; i < SIZE; i++) if (v[i]) cmd(OP_SET, i);
    chk("set_leaves", leaf_vec, v);
  endtask

  task automatic run_encode(input logic [7:0] v, input int stall_pct);
    int dones = 0, post = 0, cyc = 0, nmis = 0;
    bit stalled = 0, held = 0;
    model_encode(v);
    got_q.delete();
    cmd(OP_ENCODE, 0);
    chk("tx_valid_rise", tx_valid, 1);
    while (post < 3 && cyc < 300) begin
      if (done) begin dones++; chk("tx_valid_fin", tx_valid, 0); end
      if (dones > 0) post++;
      if (stalled) begin
        chk("tx_hold_valid", tx_valid, 1);
        chk("tx_hold_bit", tx_bit, held);
      end
      tx_ready = ($urandom_range(99) >= 32'(stall_pct));
      if (tx_valid && tx_ready) got_q.push_back(tx_bit);
      stalled = tx_valid && !tx_ready;
      held = tx_bit;
      @(negedge clk); cyc++;
    end
    tx_ready = 1'b0;
    chk("enc_timeout", cyc < 300, 1);
    chk("enc_done_count", dones, 1);
    chk("enc_len", got_q.size(), exp_q.size());
    foreach (exp_q[k]) if (k >= got_q.size() || got_q[k] != exp_q[k]) nmis++;
    chk("enc_seq_mismatches", nmis, 0);
    chk("enc_bit_count", bit_count, exp_q.size());
    chk("enc_cmd_ready", cmd_ready, 1);
  endtask

  task automatic run_decode(input logic [7:0] preset, input int vld_pct);
    int dones = 0, post = 0, cyc = 0, ptr = 0;
    bit done_err = 0;
    model_decode(preset);
    cmd(OP_DECODE, 0);
    chk("rx_ready_rise", rx_ready, 1);
    while (post < 3 && cyc < 300) begin
      if (done) begin dones++; done_err = error; chk("rx_ready_fin", rx_ready, 0); end
      if (dones > 0) post++;
      rx_valid = (ptr < stim_q.size()) && ($urandom_range(99) < 32'(vld_pct));
      rx_bit = rx_valid ? stim_q[ptr] : 1'($urandom_range(1));
      if (rx_valid && rx_ready) ptr++;
      @(negedge clk); cyc++;
    end
    rx_valid = 1'b0;
    chk("dec_timeout", cyc < 300, 1);
    chk("dec_done_count", dones, 1);
    chk("dec_err_at_done", done_err, exp_err);
    chk("dec_err_sticky", error, exp_err);
    chk("dec_leaf", leaf_vec, exp_leaf);
    chk("dec_consumed", ptr, exp_cons);
    chk("dec_bit_count", bit_count, exp_cons);
  endtask

  task automatic load_stream(input int bits, input int len);
    stim_q.delete();
    for (int k = len - 1; k >= 0; k--) stim_q.push_back(bit'((bits >> k) & 1));
  endtask

  initial begin
    logic [7:0] mv, v, w;
    logic mrd;
    int n, cyc, a, sel, saved;
    bit ref_q[$];

    tbl[0]  = '{OP_SET, 2, 8'h04, 1'b0};
    tbl[1]  = '{OP_SET, 7, 8'h84, 1'b0};
    tbl[2]  = '{OP_READ, 7, 8'h84, 1'b1};
    tbl[3]  = '{OP_READ, 3, 8'h84, 1'b0};
    tbl[4]  = '{OP_CLR, 7, 8'h04, 1'b0};
    tbl[5]  = '{OP_ROTATE, 3, 8'h20, 1'b0};
    tbl[6]  = '{OP_CLRALL, 0, 8'h00, 1'b0};
    tbl[7]  = '{OP_SET, 0, 8'h01, 1'b0};
    tbl[8]  = '{OP_SET, 7, 8'h81, 1'b0};
    tbl[9]  = '{OP_ROTATE, 3, 8'h0C, 1'b0};
    tbl[10] = '{OP_ROTATE, 0, 8'h0C, 1'b0};
    tbl[11] = '{OP_NOP, 5, 8'h0C, 1'b0};
    tbl[12] = '{OP_READ, 2, 8'h0C, 1'b1};
    tbl[13] = '{OP_ROTATE, 6, 8'h03, 1'b1};

    rst_n = 1'b0; cmd_valid = 0; cmd_op = 0; cmd_addr = 0;
    tx_ready = 0; rx_valid = 0; rx_bit = 0;
    #12;
    chk("rst_leaf", leaf_vec, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_bit_count", bit_count, 0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 1);

    foreach (tbl[k]) begin
      cmd(tbl[k].op, tbl[k].addr);
      chk($sformatf("tbl%0d_leaf", k), leaf_vec, tbl[k].exp_leaf);
      chk($sformatf("tbl%0d_rd", k), rd_data, tbl[k].exp_rd);
    end

    set_leaves(8'h04);
    run_encode(8'h04, 0);
    chk("plan_enc_04", pack_got(), 'b100110);
    set_leaves(8'h00);
    run_encode(8'h00, 0);
    chk("plan_enc_00_len", got_q.size(), 2);
    chk("plan_enc_00", pack_got(), 0);
    set_leaves(8'hFF);
    run_encode(8'hFF, 0);
    chk("plan_enc_ff", pack_got(), 'h3FFF);

    set_leaves(8'h00);
    load_stream('b100110, 6);
    run_decode(8'h00, 100);
    chk("plan_dec_04", leaf_vec, 8'h04);
    set_leaves(8'h80);
    run_decode(8'h80, 60);
    chk("plan_dec_84", leaf_vec, 8'h84);
    chk("plan_dec_84_err", error, 0);
    load_stream('b100011, 6);
    run_decode(8'h84, 100);
    chk("plan_bad_err", error, 1);
    chk("plan_bad_count", bit_count, 4);
    chk("plan_bad_leaf", leaf_vec, 8'h84);
    cmd(OP_READ, 7);
    chk("plan_read_clears_err", error, 0);
    chk("plan_read_rd", rd_data, 1);

    set_leaves(8'hA5);
    run_encode(8'hA5, 0);
    ref_q = got_q;
    run_encode(8'hA5, 50);
    saved = 0;
    foreach (ref_q[k]) if (k >= got_q.size() || got_q[k] != ref_q[k]) saved++;
    chk("a5_stall_vs_nostall", saved, 0);
    chk("a5_stall_len", got_q.size(), ref_q.size());

    set_leaves(8'hFF);
    cmd(OP_ENCODE, 0);
    tx_ready = 1'b1; n = 0; cyc = 0;
    while (n < 3 && cyc < 50) begin
      if (tx_valid) n++;
      @(negedge clk); cyc++;
    end
    chk("mid_rst_flags", n, 3);
    @(posedge clk); #2; rst_n = 1'b0; #1;
    chk("mid_rst_tx_valid", tx_valid, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_leaf", leaf_vec, 0);
    chk("mid_rst_count", bit_count, 0);
    chk("mid_rst_rx_ready", rx_ready, 0);
    chk("mid_rst_error", error, 0);
    chk("mid_rst_rd", rd_data, 0);
    tx_ready = 1'b0; n = 0;
    repeat (3) begin @(negedge clk); if (done) n++; end
    chk("mid_rst_no_done", n, 0);
    rst_n = 1'b1;
    run_encode(8'h00, 0);

    mv = 8'h00; mrd = rd_data;
    set_leaves(mv);
    for (int t = 0; t < 60; t++) begin
      sel = $urandom_range(15); a = $urandom_range(7);
      case (sel)
        0: begin cmd(OP_CLRALL, a); mv = 0; end
        1, 2, 3: begin cmd(OP_READ, a); mrd = mv[a]; end
        4, 5, 6, 7: begin cmd(OP_SET, a); mv[a] = 1'b1; end
        8, 9, 10: begin cmd(OP_CLR, a); mv[a] = 1'b0; end
        11, 12, 13, 14: begin
          cmd(OP_ROTATE, a);
          v = mv;
          for (int j = 0; j < SIZE; j++) mv[j] = v[(j - a + SIZE) % SIZE];
        end
        default: cmd(OP_NOP, a);
      endcase
      chk("rnd_op_leaf", leaf_vec, mv);
      chk("rnd_op_rd", rd_data, mrd);
    end

    for (int t = 0; t < 25; t++) begin
      v = 8'($urandom);
      if (t % 5 == 0) v = v & 8'($urandom);
      set_leaves(v);
      run_encode(v, $urandom_range(60));
    end

    for (int t = 0; t < 30; t++) begin
      v = 8'($urandom) & 8'($urandom);
      w = 8'($urandom);
      stim_q.delete();
      if (t % 2 == 0) begin
        model_encode(w);
        stim_q = exp_q;
      end
      while (stim_q.size() < 2 * (SIZE - 1)) stim_q.push_back(1'($urandom_range(1)));
      set_leaves(v);
      run_decode(v, 30 + $urandom_range(70));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
